adc_frame_builder: RTL and testbench

//   Downstream of the UDP command parser: on a one-cycle send request, builds one ADC data

---
 rtl/adc_udp_pkg.sv | 13 +
 rtl/adc_sample_packer.sv | 53 +++++
 rtl/adc_frame_builder.sv | 135 +++++++++++++
 tb/tb_adc_frame_builder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_udp_pkg.sv
// Shared types and constants for the ADC-to-UDP data path.
package adc_udp_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'b001,
        StHeader  = 3'b010,
        StPayload = 3'b100
    } state_e;

    localparam logic [15:0] HdrTagDefault = 16'hADC5;
    localparam logic [31:0] CmdSend       = 32'h73656e64;

endpackage

// File: rtl/adc_sample_packer.sv
// Packs consecutive ADC samples into 32-bit pairs: first sample low half, second high half.
module adc_sample_packer
    import adc_udp_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                pair_valid,
    output logic [31:0]         pair
);

    logic [15:0] half_q, half_d;
    logic [15:0] in_ext;
    logic        phase_q, phase_d;

    always_comb begin
        in_ext                 = '0;
        in_ext[SAMPLE_W-1:0]   = in_data;
    end

    assign pair_valid = in_valid & phase_q & ~clr;
    assign pair       = {in_ext, half_q};

    always_comb begin
        half_d  = half_q;
        phase_d = phase_q;
        if (clr) begin
            phase_d = 1'b0;
        end else if (in_valid) begin
            if (!phase_q) begin
                half_d  = in_ext;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            half_q  <= half_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/adc_frame_builder.sv
// Builds one header + WORDS_PER_FRAME payload-word frame per send request into the UDP TX FIFO.
module adc_frame_builder
    import adc_udp_pkg::*;
#(
    parameter int unsigned SAMPLE_W        = 14,
    parameter int unsigned WORDS_PER_FRAME = 256,
    parameter logic [15:0] HDR_TAG         = HdrTagDefault
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                send_req,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                tx_full,
    output logic                tx_wr_en,
    output logic [31:0]         tx_data,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output logic                overrun
);

    localparam logic [16:0] LastWord = 17'(WORDS_PER_FRAME);

    state_e      state_q, state_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        overrun_q, overrun_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [16:0] acc_cnt_q, acc_cnt_d;

    logic        pk_clr, pk_valid;
    logic [31:0] pk_pair;
    logic        last_write, pair_in, pair_drop;

    assign tx_wr_en  = out_valid_q & ~tx_full;
    assign tx_data   = out_data_q;
    assign busy      = (state_q != StIdle);
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

    // acc_cnt counts payload words accepted into the out register, so once it reaches
    // LastWord the word held there is the final one of the frame.
    assign last_write = (state_q == StPayload) && tx_wr_en && (acc_cnt_q == LastWord);
    assign pk_clr     = ((state_q == StIdle) && send_req) || last_write;

    adc_sample_packer #(
        .SAMPLE_W (SAMPLE_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (pk_clr),
        .in_valid   (adc_valid & busy),
        .in_data    (adc_data),
        .pair_valid (pk_valid),
        .pair       (pk_pair)
    );

    always_comb begin
        pair_in   = 1'b0;
        pair_drop = 1'b0;
        if (pk_valid) begin
            if (state_q == StHeader) begin
                pair_in   = tx_wr_en;
                pair_drop = ~tx_wr_en;
            end else if ((state_q == StPayload) && (acc_cnt_q < LastWord)) begin
                pair_in   = ~out_valid_q | tx_wr_en;
                pair_drop = ~pair_in;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q | pair_drop;
        out_valid_d = out_valid_q & ~tx_wr_en;
        out_data_d  = out_data_q;
        acc_cnt_d   = acc_cnt_q;

        if ((state_q == StHeader) && !out_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = {HDR_TAG, seq_q};
        end
        if (pair_in) begin
            out_valid_d = 1'b1;
            out_data_d  = pk_pair;
            acc_cnt_d   = acc_cnt_q + 17'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (send_req) begin
                    state_d   = StHeader;
                    acc_cnt_d = '0;
                end
            end
            StHeader: begin
                if (tx_wr_en) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (last_write) begin
                    state_d     = StIdle;
                    seq_d       = seq_q + 16'd1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            seq_q       <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

endmodule

// File: tb/tb_adc_frame_builder.sv
// Randomised and directed bench for adc_frame_builder against a transaction-style frame model.
module tb_adc_frame_builder;

    localparam int unsigned SW  = 14;
    localparam int unsigned WPF = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          send_req = 1'b0;
    logic          adc_valid = 1'b0;
    logic [SW-1:0] adc_data = '0;
    logic          tx_full = 1'b0;
    logic          tx_wr_en;
    logic [31:0]   tx_data;
    logic          busy;
    logic [15:0]   frame_cnt;
    logic          overrun;

    adc_frame_builder #(
        .SAMPLE_W        (SW),
        .WORDS_PER_FRAME (WPF),
        .HDR_TAG         (16'hADC5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_req  (send_req),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .tx_full   (tx_full),
        .tx_wr_en  (tx_wr_en),
        .tx_data   (tx_data),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: frame phase, one-word output slot, pending half-sample, counters.
    int          m_st;
    logic [15:0] m_seq, m_fcnt, m_half;
    bit          m_ovr, m_half_v, m_slot_v;
    logic [31:0] m_slot;
    int          m_acc;
    int          cyc_n = 0;
    logic [31:0] wlog[$];
    int          wcyc[$];

    always @(negedge clk) begin
        bit          ex_wr, pair, slot_was;
        logic [31:0] pword;
        if (!rst_n) begin
            m_st = 0; m_seq = '0; m_fcnt = '0; m_ovr = 0;
            m_half_v = 0; m_half = '0; m_slot_v = 0; m_slot = '0; m_acc = 0;
            chk("rst_wr_en", {31'b0, tx_wr_en}, 32'd0);
            chk("rst_tx_data", tx_data, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
            chk("rst_overrun", {31'b0, overrun}, 32'd0);
        end else begin
            ex_wr = m_slot_v && !tx_full;
            chk("wr_en", {31'b0, tx_wr_en}, {31'b0, ex_wr});
            if (ex_wr) chk("tx_data", tx_data, m_slot);
            chk("busy", {31'b0, busy}, {31'b0, (m_st != 0)});
            chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, m_fcnt});
            chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
            if (tx_wr_en) begin
                wlog.push_back(tx_data);
                wcyc.push_back(cyc_n);
            end

            slot_was = m_slot_v;
            pair     = 0;
            pword    = '0;
            if (m_st != 0 && adc_valid) begin
                if (m_half_v) begin
                    pair     = 1;
                    pword    = {16'(adc_data), m_half};
                    m_half_v = 0;
                end else begin
                    m_half   = 16'(adc_data);
                    m_half_v = 1;
                end
            end
            if (ex_wr) m_slot_v = 0;
            case (m_st)
                0: if (send_req) begin
                    m_st = 1; m_half_v = 0; m_acc = 0;
                end
                1: begin
                    if (!slot_was) begin
                        m_slot_v = 1; m_slot = {16'hADC5, m_seq};
                    end
                    if (pair) begin
                        if (ex_wr) begin
                            m_slot_v = 1; m_slot = pword; m_acc++;
                        end else m_ovr = 1;
                    end
                    if (ex_wr) m_st = 2;
                end
                default: begin
                    if (ex_wr && m_acc == int'(WPF)) begin
                        m_st = 0; m_seq++; m_fcnt++; m_half_v = 0;
                    end else if (pair && m_acc < int'(WPF)) begin
                        if (!slot_was || ex_wr) begin
                            m_slot_v = 1; m_slot = pword; m_acc++;
                        end else m_ovr = 1;
                    end
                end
            endcase
        end
        cyc_n++;
    end

    logic [SW-1:0] smp;
    bit            hold_smp = 0;

    task automatic cyc(input bit req, input bit v, input bit full);
        @(posedge clk);
        #1;
        send_req  = req;
        adc_valid = v;
        tx_full   = full;
        if (v) begin
            adc_data = smp;
            if (!hold_smp) smp = smp + 1'b1;
        end else begin
            adc_data = SW'($urandom);
        end
    endtask

    task automatic wait_idle(input int budget, input bit v, input string name);
        int n = 0;
        do begin
            cyc(0, v, 0);
            n++;
        end while (busy && n < budget);
        if (busy) begin
            total++;
            bad++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
    endtask

    function automatic logic [31:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        int s;
        int n;
        logic [31:0] exp1[5];
        exp1 = '{32'hADC5_0000, 32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
        smp = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1: single frame, samples 1,2,3... from the first HEADER cycle
        cyc(0, 1, 0); cyc(0, 1, 0);
        wlog.delete(); wcyc.delete();
        smp = 1;
        cyc(1, 0, 0);
        s = cyc_n;
        wait_idle(40, 1, "t1_idle");
        chk("t1_nwords", wlog.size(), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("t1_word%0d", i), wl(i), exp1[i]);
        chk("t1_hdr_latency", (wcyc.size() > 0) ? wcyc[0] - s : -1, 32'd2);
        chk("t1_frame_cnt", {16'b0, frame_cnt}, 32'd1);

        // Test 2: second frame with an ignored mid-frame send_req
        wlog.delete(); smp = 1;
        cyc(1, 0, 0);
        repeat (4) cyc(0, 1, 0);
        cyc(1, 1, 0);
        wait_idle(40, 1, "t2_idle");
        repeat (4) cyc(0, 0, 0);
        chk("t2_busy_after", {31'b0, busy}, 32'd0);
        chk("t2_nwords", wlog.size(), 32'd5);
        chk("t2_header", wl(0), 32'hADC5_0001);
        chk("t2_word1", wl(1), 32'h0002_0001);
        chk("t2_frame_cnt", {16'b0, frame_cnt}, 32'd2);

        // Test 3: FIFO full for 10 cycles during payload
        wlog.delete(); smp = 1;
        cyc(1, 0, 0);
        repeat (3) cyc(0, 1, 0);
        repeat (10) cyc(0, 1, 1);
        wait_idle(60, 1, "t3_idle");
        chk("t3_overrun", {31'b0, overrun}, 32'd1);
        chk("t3_nwords", wlog.size(), 32'd5);
        chk("t3_header", wl(0), 32'hADC5_0002);
        chk("t3_held_word", wl(2), 32'h0004_0003);

        // Test 4: full-scale sample is zero-extended
        wlog.delete(); smp = 14'h3FFF; hold_smp = 1;
        cyc(1, 0, 0);
        wait_idle(40, 1, "t4_idle");
        hold_smp = 0;
        chk("t4_word1", wl(1), 32'h3FFF_3FFF);

        // Test 5: reset mid-payload
        smp = 1;
        cyc(1, 0, 0);
        repeat (6) cyc(0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_wr_en", {31'b0, tx_wr_en}, 32'd0);
        chk("t5_async_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t5_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        chk("t5_overrun", {31'b0, overrun}, 32'd0);

        // Test 6: gapped samples, one valid every third cycle
        wlog.delete(); smp = 1;
        cyc(1, 0, 0);
        n = 0;
        do begin
            cyc(0, (n % 3 == 2), 0);
            n++;
        end while ((busy || n < 3) && n < 100);
        if (busy) begin
            total++; bad++;
            $display("FAIL t6_idle: still busy after %0d cycles, expected idle", n);
        end
        cyc(0, 0, 0);
        for (int i = 0; i < 5; i++) chk($sformatf("t6_word%0d", i), wl(i), exp1[i]);
        chk("t6_overrun", {31'b0, overrun}, 32'd0);

        // Randomised traffic with bursty back-pressure
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 < 20) cyc(($urandom_range(0, 29) == 0), 1'b1, 1'b1);
            else cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) == 0));
        end
        wait_idle(200, 1, "rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
